// File: rtl/sw_debounce_pkg.sv
// Shared constants, repeat-FSM state type and sizing helpers for the sw_debounce slice.
// The optional auto-repeat feature is enabled by defining SW_AUTOREPEAT_EN.
package sw_debounce_pkg;

    localparam int unsigned NUM_SW        = 4;
    localparam int unsigned DB_CYCLES_DEF = 500000;
    localparam int unsigned RPT_DELAY_DEF = 25000000;
    localparam int unsigned RPT_RATE_DEF  = 5000000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RPT
    } rpt_state_t;

    function automatic int unsigned cnt_width(input int unsigned terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// Single push-button channel: synchroniser, debounce counter, press-edge pulse and,
// when SW_AUTOREPEAT_EN is defined, the IDLE/WAIT/RPT auto-repeat machine.
module sw_debounce_ch
    import sw_debounce_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF,
`ifdef SW_AUTOREPEAT_EN
    parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
    parameter int unsigned RPT_RATE   = RPT_RATE_DEF,
`endif
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic sw_level,
    output logic sw_in
);

    localparam int unsigned     DB_W     = cnt_width(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_TERM  = DB_W'(DB_CYCLES - 1);
    localparam logic            IDLE_LVL = ACTIVE_LOW;

    logic            sync1;
    logic            sync2;
    logic            level;
    logic            stable;
    logic            press;
    logic [DB_W-1:0] db_cnt;
    logic            db_done;

    // The polarity-corrected level is registered after the two sync flops; this stage
    // gives the 2+DB_CYCLES acceptance latency. Sync flops reset to the idle raw level
    // so an active-low switch is not seen as pressed when reset releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= IDLE_LVL;
            sync2 <= IDLE_LVL;
            level <= 1'b0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            level <= sync2 ^ ACTIVE_LOW;
        end
    end

    assign db_done = (level != stable) && (db_cnt == DB_TERM);

    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            press <= db_done && !stable;
            if (level == stable) begin
                db_cnt <= '0;
            end else if (db_done) begin
                stable <= ~stable;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign sw_level = stable;

`ifdef SW_AUTOREPEAT_EN
    localparam int unsigned      RPT_W      = cnt_width(max_u(RPT_DELAY, RPT_RATE));
    localparam logic [RPT_W-1:0] DELAY_TERM = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_TERM  = RPT_W'(RPT_RATE - 1);

    rpt_state_t       state;
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_pulse;
    logic             stable_nxt;

    // Looking at the next stable value makes a release edge return to IDLE without
    // a final repeat pulse, even if it coincides with a terminal count.
    assign stable_nxt = db_done ? ~stable : stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rpt_cnt   <= '0;
            rpt_pulse <= 1'b0;
        end else begin
            rpt_pulse <= 1'b0;
            if (!stable_nxt) begin
                state   <= IDLE;
                rpt_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (db_done && !stable) begin
                            state   <= WAIT;
                            rpt_cnt <= '0;
                        end
                    end
                    WAIT: begin
                        if (rpt_cnt == DELAY_TERM) begin
                            state     <= RPT;
                            rpt_cnt   <= '0;
                            rpt_pulse <= 1'b1;
                        end else begin
                            rpt_cnt <= rpt_cnt + RPT_W'(1);
                        end
                    end
                    RPT: begin
                        if (rpt_cnt == RATE_TERM) begin
                            rpt_cnt   <= '0;
                            rpt_pulse <= 1'b1;
                        end else begin
                            rpt_cnt <= rpt_cnt + RPT_W'(1);
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        rpt_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign sw_in = press | rpt_pulse;
`else
    assign sw_in = press;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Four-channel push-button debouncer; glue around NUM_SW sw_debounce_ch instances.
// Defining SW_AUTOREPEAT_EN adds held-key auto-repeat pulses on sw_in.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF,
    parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
    parameter int unsigned RPT_RATE   = RPT_RATE_DEF,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_level,
    output logic [NUM_SW-1:0] sw_in
);

`ifndef SW_AUTOREPEAT_EN
    // Repeat timing is kept on the interface so both builds share one parameter set.
    if (RPT_DELAY < 2 || RPT_RATE < 2) begin : g_rpt_unused
    end
`endif

    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        sw_debounce_ch #(
            .DB_CYCLES  (DB_CYCLES),
`ifdef SW_AUTOREPEAT_EN
            .RPT_DELAY  (RPT_DELAY),
            .RPT_RATE   (RPT_RATE),
`endif
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .sw_raw   (sw_raw[i]),
            .sw_level (sw_level[i]),
            .sw_in    (sw_in[i])
        );
    end

endmodule
